// File: rtl/ssrv_mem_pkg.sv
// Shared memory-port encodings and helpers for the arbiter, membuf and instrman.
package ssrv_mem_pkg;

    localparam logic       MEM_CMD_RD = 1'b0;
    localparam logic       MEM_CMD_WR = 1'b1;

    localparam logic [1:0] MEM_W_BYTE = 2'd0;
    localparam logic [1:0] MEM_W_HALF = 2'd1;
    localparam logic [1:0] MEM_W_WORD = 2'd2;

    // Ceiling log2, usable in constant expressions.
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((32'd1 << i) < v) r = 32'(i) + 32'd1;
        end
        return r;
    endfunction

endpackage

// File: rtl/ssrv_mem_arb_if.sv
// Channel and downstream memory-port signals of the N-channel memory arbiter.
interface ssrv_mem_arb_if #(
    parameter int unsigned NUM_CH   = 2,
    parameter int unsigned XLEN     = 32,
    parameter int unsigned DATA_WID = 32
);
    logic [NUM_CH-1:0]          ch_req;
    logic [NUM_CH-1:0]          ch_cmd;
    logic [NUM_CH*2-1:0]        ch_width;
    logic [NUM_CH*XLEN-1:0]     ch_addr;
    logic [NUM_CH*DATA_WID-1:0] ch_wdata;
    logic [NUM_CH-1:0]          ch_gnt;
    logic [NUM_CH-1:0]          ch_resp;
    logic [DATA_WID-1:0]        ch_rdata;

    logic                       mem_req;
    logic                       mem_cmd;
    logic [1:0]                 mem_width;
    logic [XLEN-1:0]            mem_addr;
    logic [DATA_WID-1:0]        mem_wdata;
    logic                       mem_gnt;
    logic [DATA_WID-1:0]        mem_rdata;
    logic                       mem_resp;
    logic                       err_resp;

    // Arbiter side.
    modport slave (
        input  ch_req, ch_cmd, ch_width, ch_addr, ch_wdata,
        output ch_gnt, ch_resp, ch_rdata,
        output mem_req, mem_cmd, mem_width, mem_addr, mem_wdata,
        input  mem_gnt, mem_rdata, mem_resp,
        output err_resp
    );

    // Environment side: upstream channels plus the downstream memory.
    modport master (
        output ch_req, ch_cmd, ch_width, ch_addr, ch_wdata,
        input  ch_gnt, ch_resp, ch_rdata,
        input  mem_req, mem_cmd, mem_width, mem_addr, mem_wdata,
        output mem_gnt, mem_rdata, mem_resp,
        input  err_resp
    );

endinterface

// File: rtl/ssrv_tag_fifo.sv
// In-order tag FIFO recording which channel owns each outstanding transaction.
module ssrv_tag_fifo
    import ssrv_mem_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WID   = 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           push,
    input  logic           pop,
    input  logic [WID-1:0] din,
    output logic [WID-1:0] head,
    output logic           full,
    output logic           empty
);

    localparam int unsigned PW = clog2(DEPTH);

    logic [WID-1:0] mem [DEPTH];
    logic [PW-1:0]  rd_ptr;
    logic [PW-1:0]  wr_ptr;
    logic [PW:0]    cnt;

    assign full  = (cnt == (PW+1)'(DEPTH));
    assign empty = (cnt == '0);
    assign head  = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= din;
    end

    // Pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   cnt <= cnt + (PW+1)'(1);
                2'b01:   cnt <= cnt - (PW+1)'(1);
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: rtl/ssrv_mem_arb.sv
// N-channel memory-port arbiter with in-order response routing.
// Build option: SSRV_ARB_FIXED_PRIO_EN selects fixed lowest-index priority instead of round-robin.
module ssrv_mem_arb
    import ssrv_mem_pkg::*;
#(
    parameter int unsigned NUM_CH   = 2,
    parameter int unsigned XLEN     = 32,
    parameter int unsigned DATA_WID = 32,
    parameter int unsigned OUTSTD   = 4
) (
    input  logic            clk,
    input  logic            rst,
    ssrv_mem_arb_if.slave   bus
);

    localparam int unsigned IW = (NUM_CH > 1) ? clog2(NUM_CH) : 1;

    logic [IW-1:0] arb_sel;
    logic [IW-1:0] sel;
    logic [IW-1:0] lock_idx;
    logic          lock_vld;
    logic [IW-1:0] head;
    logic          full;
    logic          empty;
    logic          pop;
    logic          accept;
    logic          err_q;

`ifdef SSRV_ARB_FIXED_PRIO_EN
    // Lowest requesting index wins.
    always_comb begin
        arb_sel = '0;
        for (int i = int'(NUM_CH) - 1; i >= 0; i--) begin
            if (bus.ch_req[IW'(i)]) arb_sel = IW'(i);
        end
    end
`else
    logic [IW-1:0] rr_last;

    // Scan from rr_last+1 upward; iterating backwards lets the nearest requester win.
    always_comb begin
        arb_sel = '0;
        for (int i = int'(NUM_CH); i >= 1; i--) begin
            if (bus.ch_req[IW'((int'(rr_last) + i) % int'(NUM_CH))])
                arb_sel = IW'((int'(rr_last) + i) % int'(NUM_CH));
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)        rr_last <= IW'(NUM_CH - 1);
        else if (accept) rr_last <= sel;
    end
`endif

    assign sel    = lock_vld ? lock_idx : arb_sel;
    assign pop    = rst & bus.mem_resp & ~empty;
    assign bus.mem_req = rst & (|bus.ch_req) & (~full | pop);
    assign accept = bus.mem_req & bus.mem_gnt;

    // Freeze the selection while the downstream port stalls a request.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lock_vld <= 1'b0;
            lock_idx <= '0;
        end else if (accept) begin
            lock_vld <= 1'b0;
        end else if (bus.mem_req) begin
            lock_vld <= 1'b1;
            lock_idx <= sel;
        end
    end

    always_comb begin
        bus.ch_gnt  = '0;
        bus.ch_resp = '0;
        if (accept) bus.ch_gnt[sel]  = 1'b1;
        if (pop)    bus.ch_resp[head] = 1'b1;
    end

    assign bus.ch_rdata  = pop ? bus.mem_rdata : '0;
    assign bus.mem_cmd   = bus.mem_req ? bus.ch_cmd[sel] : 1'b0;
    assign bus.mem_width = bus.mem_req ? bus.ch_width[32'(sel)*2 +: 2] : 2'b00;
    assign bus.mem_addr  = bus.mem_req ? bus.ch_addr[32'(sel)*XLEN +: XLEN] : '0;
    assign bus.mem_wdata = bus.mem_req ? bus.ch_wdata[32'(sel)*DATA_WID +: DATA_WID] : '0;

    // Sticky flag for a response with nothing outstanding.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                         err_q <= 1'b0;
        else if (bus.mem_resp && empty)   err_q <= 1'b1;
    end
    assign bus.err_resp = err_q;

    ssrv_tag_fifo #(
        .DEPTH (OUTSTD),
        .WID   (IW)
    ) u_tag_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (accept),
        .pop   (pop),
        .din   (sel),
        .head  (head),
        .full  (full),
        .empty (empty)
    );

endmodule
